// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - state codes, opcode/funct constants and datapath select codes
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_MEM    = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_JUMP   = 3'd3,
        CLS_TRAP   = 3'd4
    } iclass_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] MEM_W = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_B = 2'd2;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    localparam logic [1:0] REGSRC_ALU = 2'd0;
    localparam logic [1:0] REGSRC_MEM = 2'd1;
    localparam logic [1:0] REGSRC_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_inst_decode.sv
// rtl/multicycle_ctrl_inst_decode.sv - combinational opcode/funct decode into class and selects
module inst_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_cls,
    output logic       o_is_load,
    output logic       o_is_shift,
    output logic       o_is_itype,
    output logic [3:0] o_alu_op,
    output logic [1:0] o_mem_op,
    output logic       o_mem_ext,
    output logic [1:0] o_reg_dst,
    output logic       o_is_bne,
    output logic       o_is_jr,
    output logic       o_link,
    output logic       o_illegal_inst
);

    always_comb begin
        o_cls      = CLS_TRAP;
        o_is_load  = 1'b0;
        o_is_shift = 1'b0;
        o_is_itype = 1'b0;
        o_alu_op   = ALU_NOP;
        o_mem_op   = MEM_W;
        o_mem_ext  = EXT_ZERO;
        o_reg_dst  = REGDST_RT;
        o_is_bne   = 1'b0;
        o_is_jr    = 1'b0;
        o_link     = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_reg_dst = REGDST_RD;
                case (i_funct)
                    F_ADD:  begin o_cls = CLS_ALU; o_alu_op = ALU_ADD; end
                    F_SUB:  begin o_cls = CLS_ALU; o_alu_op = ALU_SUB; end
                    F_AND:  begin o_cls = CLS_ALU; o_alu_op = ALU_AND; end
                    F_OR:   begin o_cls = CLS_ALU; o_alu_op = ALU_OR;  end
                    F_SLT:  begin o_cls = CLS_ALU; o_alu_op = ALU_SLT; end
                    F_SLL:  begin o_cls = CLS_ALU; o_alu_op = ALU_SLL; o_is_shift = 1'b1; end
                    F_SRL:  begin o_cls = CLS_ALU; o_alu_op = ALU_SRL; o_is_shift = 1'b1; end
                    F_SRA:  begin o_cls = CLS_ALU; o_alu_op = ALU_SRA; o_is_shift = 1'b1; end
                    F_JR:   begin o_cls = CLS_JUMP; o_is_jr = 1'b1; end
                    F_JALR: begin o_cls = CLS_JUMP; o_is_jr = 1'b1; o_link = 1'b1; end
                    default: o_reg_dst = REGDST_RT;
                endcase
            end
            OP_J:    o_cls = CLS_JUMP;
            OP_JAL:  begin o_cls = CLS_JUMP; o_link = 1'b1; o_reg_dst = REGDST_R31; end
            OP_BEQ:  o_cls = CLS_BRANCH;
            OP_BNE:  begin o_cls = CLS_BRANCH; o_is_bne = 1'b1; end
            OP_ADDI: begin o_cls = CLS_ALU; o_is_itype = 1'b1; o_alu_op = ALU_ADD; end
            OP_SLTI: begin o_cls = CLS_ALU; o_is_itype = 1'b1; o_alu_op = ALU_SLT; end
            OP_LUI:  begin o_cls = CLS_ALU; o_is_itype = 1'b1; o_alu_op = ALU_LUI; end
            OP_LB:   begin o_cls = CLS_MEM; o_is_load = 1'b1; o_mem_op = MEM_B; o_mem_ext = EXT_SIGN; end
            OP_LH:   begin o_cls = CLS_MEM; o_is_load = 1'b1; o_mem_op = MEM_H; o_mem_ext = EXT_SIGN; end
            OP_LW:   begin o_cls = CLS_MEM; o_is_load = 1'b1; o_mem_op = MEM_W; end
            OP_LBU:  begin o_cls = CLS_MEM; o_is_load = 1'b1; o_mem_op = MEM_B; end
            OP_LHU:  begin o_cls = CLS_MEM; o_is_load = 1'b1; o_mem_op = MEM_H; end
            OP_SB:   begin o_cls = CLS_MEM; o_mem_op = MEM_B; end
            OP_SH:   begin o_cls = CLS_MEM; o_mem_op = MEM_H; end
            OP_SW:   begin o_cls = CLS_MEM; o_mem_op = MEM_W; end
            default: o_cls = CLS_TRAP;
        endcase
    end

    assign o_illegal_inst = (o_cls == CLS_TRAP);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle sequencer driving MIPS-subset datapath enables and selects
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       RegSrc,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       MemOp,
    output logic             MemEXT,
    output logic [1:0]       NPCOp,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] inst_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0] w_cls;
    logic       w_is_load, w_is_shift, w_is_itype, w_mem_ext;
    logic       w_is_bne, w_is_jr, w_link, w_illegal_inst;
    logic [3:0] w_alu_op;
    logic [1:0] w_mem_op, w_reg_dst;

    logic w_pcwr, w_irwr, w_regwrite, w_memwrite, w_illegal;

    inst_decode u_decode (
        .i_opcode       (opcode),
        .i_funct        (funct),
        .o_cls          (w_cls),
        .o_is_load      (w_is_load),
        .o_is_shift     (w_is_shift),
        .o_is_itype     (w_is_itype),
        .o_alu_op       (w_alu_op),
        .o_mem_op       (w_mem_op),
        .o_mem_ext      (w_mem_ext),
        .o_reg_dst      (w_reg_dst),
        .o_is_bne       (w_is_bne),
        .o_is_jr        (w_is_jr),
        .o_link         (w_link),
        .o_illegal_inst (w_illegal_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (PCWr)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    CLS_ALU:    w_next = S_EXEC;
                    CLS_MEM:    w_next = S_MEMADR;
                    CLS_BRANCH: w_next = S_BRANCH;
                    CLS_JUMP:   w_next = S_JUMP;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_EXEC:   w_next = S_ALUWB;
            S_MEMADR: w_next = w_is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcwr     = 1'b0;
        w_irwr     = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_illegal  = 1'b0;
        RegDst     = REGDST_RT;
        RegSrc     = REGSRC_ALU;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        ALUOp      = ALU_NOP;
        MemOp      = MEM_W;
        MemEXT     = EXT_ZERO;
        NPCOp      = NPC_PLUS4;
        case (r_state)
            S_FETCH: w_irwr = mem_ready;
            S_EXEC: begin
                ALUSrcA = w_is_shift;
                ALUSrcB = w_is_itype;
                ALUOp   = w_alu_op;
            end
            S_ALUWB: begin
                ALUSrcA    = w_is_shift;
                ALUSrcB    = w_is_itype;
                ALUOp      = w_alu_op;
                w_regwrite = 1'b1;
                RegDst     = w_reg_dst;
                w_pcwr     = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcB = 1'b1;
                ALUOp   = ALU_ADD;
            end
            S_MEMRD: begin
                ALUSrcB = 1'b1;
                ALUOp   = ALU_ADD;
                MemOp   = w_mem_op;
                MemEXT  = w_mem_ext;
            end
            // Load width/extension stay valid while the read data is written back.
            S_MEMWB: begin
                MemOp      = w_mem_op;
                MemEXT     = w_mem_ext;
                w_regwrite = 1'b1;
                RegSrc     = REGSRC_MEM;
                w_pcwr     = 1'b1;
            end
            S_MEMWR: begin
                ALUSrcB    = 1'b1;
                ALUOp      = ALU_ADD;
                MemOp      = w_mem_op;
                w_memwrite = mem_ready;
                w_pcwr     = mem_ready;
            end
            S_BRANCH: begin
                ALUOp  = ALU_SUB;
                w_pcwr = 1'b1;
                if (w_is_bne ^ Zero)
                    NPCOp = NPC_BRANCH;
            end
            S_JUMP: begin
                w_pcwr     = 1'b1;
                NPCOp      = w_is_jr ? NPC_JR : NPC_JUMP;
                w_regwrite = w_link;
                if (w_link) begin
                    RegDst = w_reg_dst;
                    RegSrc = REGSRC_PC4;
                end
            end
            S_TRAP: begin
                w_illegal = w_illegal_inst | 1'b1;
                w_pcwr    = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWr     = w_pcwr & ~rst;
    assign IRWr     = w_irwr & ~rst;
    assign RegWrite = w_regwrite & ~rst;
    assign MemWrite = w_memwrite & ~rst;
    assign illegal  = w_illegal & ~rst;
    assign state    = r_state;
    assign inst_cnt = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and randomized instruction stream against a per-instruction model
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       Zero, mem_ready;
    logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrcA, ALUSrcB, MemEXT, illegal;
    logic [1:0] RegDst, RegSrc, MemOp, NPCOp;
    logic [3:0] ALUOp, state, inst_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .RegDst(RegDst), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemOp(MemOp), .MemEXT(MemEXT),
        .NPCOp(NPCOp), .illegal(illegal), .state(state), .inst_cnt(inst_cnt)
    );

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JMP = 4, K_TRAP = 5;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;
    int pw, mw;

    logic [5:0] t_op, t_fn;
    int         t_kind;
    logic [3:0] t_alu;
    logic [1:0] t_memop;
    logic       t_shift, t_itype, t_rtype, t_memext, t_bne, t_jr, t_jal, t_jalr, t_zero;

    logic [11:0] itab [27] = '{
        {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
        {6'b000000, 6'b100101}, {6'b000000, 6'b101010}, {6'b000000, 6'b000000},
        {6'b000000, 6'b000010}, {6'b000000, 6'b000011}, {6'b000000, 6'b001000},
        {6'b000000, 6'b001001}, {6'b000010, 6'b010101}, {6'b000011, 6'b110011},
        {6'b000100, 6'b000111}, {6'b000101, 6'b100000}, {6'b001000, 6'b000001},
        {6'b001010, 6'b111000}, {6'b001111, 6'b000000}, {6'b100000, 6'b001001},
        {6'b100001, 6'b000000}, {6'b100011, 6'b100010}, {6'b100100, 6'b000011},
        {6'b100101, 6'b010000}, {6'b101000, 6'b000000}, {6'b101001, 6'b001000},
        {6'b101011, 6'b100000}, {6'b111111, 6'b000000}, {6'b000000, 6'b111111}
    };

    // Expected behaviour of one instruction, written straight from the opcode table.
    task automatic describe(input logic [5:0] op, input logic [5:0] fn);
        t_op = op; t_fn = fn; t_kind = K_TRAP; t_alu = ALU_NOP; t_memop = MEM_W;
        t_shift = 0; t_itype = 0; t_rtype = 0; t_memext = 0;
        t_bne = 0; t_jr = 0; t_jal = 0; t_jalr = 0;
        if (op == 6'b000000) begin
            t_rtype = 1;
            case (fn)
                6'b100000: begin t_kind = K_ALU; t_alu = ALU_ADD; end
                6'b100010: begin t_kind = K_ALU; t_alu = ALU_SUB; end
                6'b100100: begin t_kind = K_ALU; t_alu = ALU_AND; end
                6'b100101: begin t_kind = K_ALU; t_alu = ALU_OR;  end
                6'b101010: begin t_kind = K_ALU; t_alu = ALU_SLT; end
                6'b000000: begin t_kind = K_ALU; t_alu = ALU_SLL; t_shift = 1; end
                6'b000010: begin t_kind = K_ALU; t_alu = ALU_SRL; t_shift = 1; end
                6'b000011: begin t_kind = K_ALU; t_alu = ALU_SRA; t_shift = 1; end
                6'b001000: begin t_kind = K_JMP; t_jr = 1; end
                6'b001001: begin t_kind = K_JMP; t_jr = 1; t_jalr = 1; end
                default:   t_kind = K_TRAP;
            endcase
        end else begin
            case (op)
                6'b000010: t_kind = K_JMP;
                6'b000011: begin t_kind = K_JMP; t_jal = 1; end
                6'b000100: t_kind = K_BR;
                6'b000101: begin t_kind = K_BR; t_bne = 1; end
                6'b001000: begin t_kind = K_ALU; t_itype = 1; t_alu = ALU_ADD; end
                6'b001010: begin t_kind = K_ALU; t_itype = 1; t_alu = ALU_SLT; end
                6'b001111: begin t_kind = K_ALU; t_itype = 1; t_alu = ALU_LUI; end
                6'b100000: begin t_kind = K_LOAD; t_memop = MEM_B; t_memext = 1; end
                6'b100001: begin t_kind = K_LOAD; t_memop = MEM_H; t_memext = 1; end
                6'b100011: begin t_kind = K_LOAD; t_memop = MEM_W; end
                6'b100100: begin t_kind = K_LOAD; t_memop = MEM_B; end
                6'b100101: begin t_kind = K_LOAD; t_memop = MEM_H; end
                6'b101000: begin t_kind = K_STORE; t_memop = MEM_B; end
                6'b101001: begin t_kind = K_STORE; t_memop = MEM_H; end
                6'b101011: begin t_kind = K_STORE; t_memop = MEM_W; end
                default:   t_kind = K_TRAP;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (op=%b fn=%b)", tag, obs, exp, t_op, t_fn);
        end
    endtask

    task automatic cycle(input logic [3:0] st, input logic mr, input logic rst_v);
        logic e_pcwr, e_irwr, e_rw, e_mw, e_ill, e_sa, e_sb, e_ext, skip_mem;
        logic [1:0] e_rd, e_rs, e_mop, e_npc;
        logic [3:0] e_alu;
        @(negedge clk);
        rst = rst_v;
        mem_ready = mr;
        Zero = t_zero;
        if (st == S_FETCH) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
        end else begin
            opcode = t_op;
            funct  = t_fn;
        end
        #1;
        {e_pcwr, e_irwr, e_rw, e_mw, e_ill, e_sa, e_sb, e_ext, skip_mem} = '0;
        e_rd = 0; e_rs = 0; e_mop = 0; e_npc = NPC_PLUS4; e_alu = ALU_NOP;
        case (st)
            S_FETCH: e_irwr = mr;
            S_EXEC: begin e_sa = t_shift; e_sb = t_itype; e_alu = t_alu; end
            S_ALUWB: begin
                e_sa = t_shift; e_sb = t_itype; e_alu = t_alu;
                e_rw = 1; e_rd = t_rtype ? 2'd1 : 2'd0; e_pcwr = 1;
            end
            S_MEMADR: begin e_sb = 1; e_alu = ALU_ADD; end
            S_MEMRD: begin e_sb = 1; e_alu = ALU_ADD; e_mop = t_memop; e_ext = t_memext; end
            S_MEMWB: begin e_rw = 1; e_rs = 1; e_pcwr = 1; skip_mem = 1; end
            S_MEMWR: begin e_sb = 1; e_alu = ALU_ADD; e_mop = t_memop; e_mw = mr; e_pcwr = mr; end
            S_BRANCH: begin
                e_alu = ALU_SUB; e_pcwr = 1;
                if ((!t_bne && t_zero) || (t_bne && !t_zero)) e_npc = NPC_BRANCH;
            end
            S_JUMP: begin
                e_pcwr = 1;
                e_npc = t_jr ? NPC_JR : NPC_JUMP;
                if (t_jal)  begin e_rw = 1; e_rd = 2; e_rs = 2; end
                if (t_jalr) begin e_rw = 1; e_rd = 1; e_rs = 2; end
            end
            S_TRAP: begin e_ill = 1; e_pcwr = 1; end
            default: ;
        endcase
        if (rst_v) {e_pcwr, e_irwr, e_rw, e_mw, e_ill} = '0;
        chk("state", state, st);
        chk("inst_cnt", inst_cnt, 32'(model_cnt % 16));
        chk("PCWr", PCWr, e_pcwr);
        chk("IRWr", IRWr, e_irwr);
        chk("RegWrite", RegWrite, e_rw);
        chk("MemWrite", MemWrite, e_mw);
        chk("illegal", illegal, e_ill);
        chk("RegDst", RegDst, e_rd);
        chk("RegSrc", RegSrc, e_rs);
        chk("ALUSrcA", ALUSrcA, e_sa);
        chk("ALUSrcB", ALUSrcB, e_sb);
        chk("ALUOp", ALUOp, e_alu);
        chk("NPCOp", NPCOp, e_npc);
        if (!skip_mem) begin
            chk("MemOp", MemOp, e_mop);
            chk("MemEXT", MemEXT, e_ext);
        end
        if (PCWr) pw++;
        if (MemWrite) mw++;
        if (rst_v) model_cnt = 0;
        else if (e_pcwr) model_cnt++;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
        describe(op, fn);
        t_zero = z;
        pw = 0;
        mw = 0;
        repeat (wf) cycle(S_FETCH, 1'b0, 1'b0);
        cycle(S_FETCH, 1'b1, 1'b0);
        cycle(S_DECODE, 1'($urandom), 1'b0);
        case (t_kind)
            K_ALU: begin
                cycle(S_EXEC, 1'($urandom), 1'b0);
                cycle(S_ALUWB, 1'($urandom), 1'b0);
            end
            K_LOAD: begin
                cycle(S_MEMADR, 1'($urandom), 1'b0);
                repeat (wm) cycle(S_MEMRD, 1'b0, 1'b0);
                cycle(S_MEMRD, 1'b1, 1'b0);
                cycle(S_MEMWB, 1'($urandom), 1'b0);
            end
            K_STORE: begin
                cycle(S_MEMADR, 1'($urandom), 1'b0);
                repeat (wm) cycle(S_MEMWR, 1'b0, 1'b0);
                cycle(S_MEMWR, 1'b1, 1'b0);
            end
            K_BR:    cycle(S_BRANCH, 1'($urandom), 1'b0);
            K_JMP:   cycle(S_JUMP, 1'($urandom), 1'b0);
            default: cycle(S_TRAP, 1'($urandom), 1'b0);
        endcase
        chk("pcwr_once", pw, 1);
        if (t_kind == K_STORE) chk("memwrite_once", mw, 1);
    endtask

    initial begin
        logic [11:0] ent;
        rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; Zero = 1'b0;
        describe(6'b000000, 6'b100000);
        t_zero = 1'b0;
        cycle(S_FETCH, 1'b1, 1'b1);
        cycle(S_FETCH, 1'b1, 1'b1);

        // add abandoned by a two-cycle reset in EXEC
        cycle(S_FETCH, 1'b1, 1'b0);
        cycle(S_DECODE, 1'b1, 1'b0);
        cycle(S_EXEC, 1'b1, 1'b1);
        cycle(S_FETCH, 1'b1, 1'b1);

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 1);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000011, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            ent = itab[$urandom_range(0, 26)];
            run_instr(ent[11:6], ent[5:0], 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
